// File: rtl/password_pkg.sv
// ---------------------------------------------------------------------------
// password_pkg
// Shared definitions for the 4-digit password lock.
//   state_t          : controller state encoding, also driven onto state_code
//   DEF_DIG_1..4     : code loaded at reset (2,0,1,6)
//   DIGIT_MAX        : highest legal digit value; shared with encoder and HEX driver
//   CODE_LEN         : number of digits in a code
//   max3()           : constant helper used to size the shared timer
// ---------------------------------------------------------------------------
package password_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ENTRY    = 3'd1,
      ST_UNLOCKED = 3'd2,
      ST_ERROR    = 3'd3,
      ST_LOCKOUT  = 3'd4,
      ST_PROG     = 3'd5
   } state_t;

   localparam int unsigned DEF_DIG_1 = 2;
   localparam int unsigned DEF_DIG_2 = 0;
   localparam int unsigned DEF_DIG_3 = 1;
   localparam int unsigned DEF_DIG_4 = 6;

   localparam int unsigned DIGIT_MAX = 9;
   localparam int unsigned CODE_LEN  = 4;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage : password_pkg

// File: rtl/password_timer.sv
// ---------------------------------------------------------------------------
// password_timer
// Loadable down-counter shared by every timed state of the controller.
// The count decrements once per cycle while nonzero and holds at zero.
// A state whose timer is loaded with N-1 on entry lasts exactly N cycles.
//   clk        in   system clock
//   rst        in   synchronous active-high reset (count -> 0)
//   load       in   load load_value this cycle (takes priority)
//   load_value in   WIDTH value to load
//   zero       out  count is zero
// ---------------------------------------------------------------------------
module password_timer #(
   parameter int unsigned WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (count_q != '0) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule : password_timer

// File: rtl/password_seq_ctrl.sv
// ---------------------------------------------------------------------------
// password_seq_ctrl
// Sequencing controller for the 4-digit password lock. Checks digit events
// against the stored code, rejects on the first wrong digit, counts failed
// attempts with a timed lockout, relocks automatically after a timed unlock,
// and lets the code be re-programmed from the unlocked state.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   digit_valid  in   one-cycle pulse: new digit pressed
//   digit        in   digit value, sampled when digit_valid=1
//   prog_req     in   one-cycle pulse: request code change
//   state_code   out  current state encoding (see password_pkg::state_t)
//   digit_count  out  digits accepted in the current entry
//   fail_count   out  consecutive failed attempts (saturates at MAX_FAIL)
//   unlocked     out  high while UNLOCKED
//   locked       out  high while LOCKOUT
//   error_pulse  out  one-cycle pulse on entry to ERROR
//   code_updated out  one-cycle pulse when a new code is committed
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module password_seq_ctrl
   import password_pkg::*;
#(
   parameter int unsigned DIG_1         = DEF_DIG_1,
   parameter int unsigned DIG_2         = DEF_DIG_2,
   parameter int unsigned DIG_3         = DEF_DIG_3,
   parameter int unsigned DIG_4         = DEF_DIG_4,
   parameter int unsigned WIRE_SIZE     = 4,
   parameter int unsigned MAX_FAIL      = 3,
   parameter int unsigned ERR_CYCLES    = 250,
   parameter int unsigned UNLOCK_CYCLES = 1000,
   parameter int unsigned LOCK_CYCLES   = 2000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 digit_valid,
   input  logic [WIRE_SIZE-1:0] digit,
   input  logic                 prog_req,
   output logic [2:0]           state_code,
   output logic [2:0]           digit_count,
   output logic [2:0]           fail_count,
   output logic                 unlocked,
   output logic                 locked,
   output logic                 error_pulse,
   output logic                 code_updated
);

   localparam int unsigned MAX_CYC = max3(ERR_CYCLES, UNLOCK_CYCLES, LOCK_CYCLES);
   localparam int unsigned TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

   localparam logic [TW-1:0]        ERR_LOAD    = TW'(ERR_CYCLES - 1);
   localparam logic [TW-1:0]        UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0]        LOCK_LOAD   = TW'(LOCK_CYCLES - 1);
   localparam logic [WIRE_SIZE-1:0] DMAX        = WIRE_SIZE'(DIGIT_MAX);
   localparam logic [2:0]           FAIL_SAT    = 3'(MAX_FAIL);
   localparam logic [2:0]           LAST_IDX    = 3'(CODE_LEN - 1);

   state_t               state_q, state_d;
   logic [2:0]           dcnt_q, dcnt_d;
   logic [2:0]           fail_q, fail_d;
   logic                 unl_q, lock_q, err_q, upd_q;
   logic                 err_d, upd_d;
   logic [WIRE_SIZE-1:0] code_q   [CODE_LEN];
   logic [WIRE_SIZE-1:0] shadow_q [CODE_LEN];

   logic                 tmr_load;
   logic [TW-1:0]        tmr_value;
   logic                 tmr_zero;
   logic                 shadow_we;
   logic                 commit;
   logic                 digit_ok;

   password_timer #(.WIDTH(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (tmr_load),
      .load_value (tmr_value),
      .zero       (tmr_zero)
   );

   assign digit_ok = (digit <= DMAX);

   // NOTE: every signal assigned here gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      fail_d    = fail_q;
      err_d     = 1'b0;
      upd_d     = 1'b0;
      tmr_load  = 1'b0;
      tmr_value = '0;
      shadow_we = 1'b0;
      commit    = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_ENTRY: begin
            if (digit_valid) begin
               if (digit_ok && (digit == code_q[dcnt_q[1:0]])) begin
                  if (dcnt_q == LAST_IDX) begin
                     state_d   = ST_UNLOCKED;
                     dcnt_d    = '0;
                     fail_d    = '0;
                     tmr_load  = 1'b1;
                     tmr_value = UNLOCK_LOAD;
                  end else begin
                     state_d = ST_ENTRY;
                     dcnt_d  = dcnt_q + 3'd1;
                  end
               end else begin
                  // Reject at the first wrong digit rather than after four.
                  state_d   = ST_ERROR;
                  err_d     = 1'b1;
                  dcnt_d    = '0;
                  fail_d    = (fail_q >= FAIL_SAT) ? FAIL_SAT : fail_q + 3'd1;
                  tmr_load  = 1'b1;
                  tmr_value = ERR_LOAD;
               end
            end
         end

         ST_UNLOCKED: begin
            // prog_req outranks both a same-cycle relock and a stray digit.
            if (prog_req) begin
               state_d = ST_PROG;
               dcnt_d  = '0;
            end else if (tmr_zero) begin
               state_d = ST_IDLE;
            end
         end

         ST_ERROR: begin
            if (tmr_zero) begin
               if (fail_q == FAIL_SAT) begin
                  state_d   = ST_LOCKOUT;
                  tmr_load  = 1'b1;
                  tmr_value = LOCK_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_LOCKOUT: begin
            if (tmr_zero) begin
               state_d = ST_IDLE;
               fail_d  = '0;
            end
         end

         ST_PROG: begin
            if (digit_valid && digit_ok) begin
               shadow_we = 1'b1;
               if (dcnt_q == LAST_IDX) begin
                  commit  = 1'b1;
                  upd_d   = 1'b1;
                  state_d = ST_IDLE;
                  dcnt_d  = '0;
               end else begin
                  dcnt_d = dcnt_q + 3'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         dcnt_q    <= '0;
         fail_q    <= '0;
         unl_q     <= 1'b0;
         lock_q    <= 1'b0;
         err_q     <= 1'b0;
         upd_q     <= 1'b0;
         code_q[0] <= WIRE_SIZE'(DIG_1);
         code_q[1] <= WIRE_SIZE'(DIG_2);
         code_q[2] <= WIRE_SIZE'(DIG_3);
         code_q[3] <= WIRE_SIZE'(DIG_4);
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         fail_q  <= fail_d;
         unl_q   <= (state_d == ST_UNLOCKED);
         lock_q  <= (state_d == ST_LOCKOUT);
         err_q   <= err_d;
         upd_q   <= upd_d;
         if (commit) begin
            // The last digit goes straight in; the first three come from the shadow.
            code_q[0] <= shadow_q[0];
            code_q[1] <= shadow_q[1];
            code_q[2] <= shadow_q[2];
            code_q[3] <= digit;
         end
      end
   end

   // NOTE: the shadow code needs no reset: each PROG pass rewrites every
   // entry that a commit reads, and reset simply drops a half-entered code.
   always_ff @(posedge clk) begin
      if (shadow_we) begin
         shadow_q[dcnt_q[1:0]] <= digit;
      end
   end

   assign state_code   = state_q;
   assign digit_count  = dcnt_q;
   assign fail_count   = fail_q;
   assign unlocked     = unl_q;
   assign locked       = lock_q;
   assign error_pulse  = err_q;
   assign code_updated = upd_q;

endmodule : password_seq_ctrl

// File: tb/tb_password_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_password_seq_ctrl
// Directed, table-driven bench for password_seq_ctrl. Inputs change 1 ns
// after a rising edge and outputs are sampled 1 ns after the next one.
// ---------------------------------------------------------------------------
module tb_password_seq_ctrl;

   localparam int unsigned ERR_CYCLES    = 250;
   localparam int unsigned UNLOCK_CYCLES = 1000;
   localparam int unsigned LOCK_CYCLES   = 2000;

   logic       clk;
   logic       rst;
   logic       digit_valid;
   logic [3:0] digit;
   logic       prog_req;
   logic [2:0] state_code;
   logic [2:0] digit_count;
   logic [2:0] fail_count;
   logic       unlocked;
   logic       locked;
   logic       error_pulse;
   logic       code_updated;

   int total = 0;
   int bad   = 0;

   password_seq_ctrl #(
      .DIG_1         (2),
      .DIG_2         (0),
      .DIG_3         (1),
      .DIG_4         (6),
      .WIRE_SIZE     (4),
      .MAX_FAIL      (3),
      .ERR_CYCLES    (ERR_CYCLES),
      .UNLOCK_CYCLES (UNLOCK_CYCLES),
      .LOCK_CYCLES   (LOCK_CYCLES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .digit_valid  (digit_valid),
      .digit        (digit),
      .prog_req     (prog_req),
      .state_code   (state_code),
      .digit_count  (digit_count),
      .fail_count   (fail_count),
      .unlocked     (unlocked),
      .locked       (locked),
      .error_pulse  (error_pulse),
      .code_updated (code_updated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       dv;
      logic [3:0] d;
      logic       pr;
      logic [2:0] st;
      logic [2:0] dc;
      logic [2:0] fc;
      logic       un;
      logic       lk;
      logic       ep;
      logic       cu;
   } vec_t;

   vec_t vt [17];

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got st/dc/fc/un/lk/ep/cu=%b, wanted %b", name, act, exp);
      end
   endtask

   task automatic expect_outs(input string name,
                              input logic [2:0] st, input logic [2:0] dc, input logic [2:0] fc,
                              input logic un, input logic lk, input logic ep, input logic cu);
      check(name,
            {state_code, digit_count, fail_count, unlocked, locked, error_pulse, code_updated},
            {st, dc, fc, un, lk, ep, cu});
   endtask

   // One clock of stimulus; outputs are valid for sampling on return.
   task automatic step(input logic dv, input logic [3:0] d, input logic pr);
      digit_valid = dv;
      digit       = d;
      prog_req    = pr;
      @(posedge clk);
      #1;
      digit_valid = 1'b0;
      digit       = 4'd0;
      prog_req    = 1'b0;
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 4'd0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] e);
      step(1'b1, a, 1'b0);
      step(1'b1, b, 1'b0);
      step(1'b1, c, 1'b0);
      step(1'b1, e, 1'b0);
   endtask

   initial begin
      rst         = 1'b1;
      digit_valid = 1'b0;
      digit       = 4'd0;
      prog_req    = 1'b0;
      #2;

      //             dv  d      pr    st    dc    fc    un    lk    ep    cu
      vt[0]  = '{1'b0, 4'd0,  1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 4'd2,  1'b0, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 4'd0,  1'b0, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 4'd1,  1'b0, 3'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 4'd6,  1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{1'b0, 4'd0,  1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 4'd5,  1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 4'd0,  1'b1, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 4'd1,  1'b0, 3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{1'b1, 4'd12, 1'b0, 3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[10] = '{1'b0, 4'd0,  1'b1, 3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[11] = '{1'b1, 4'd2,  1'b0, 3'd5, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[12] = '{1'b1, 4'd3,  1'b0, 3'd5, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[13] = '{1'b1, 4'd4,  1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[14] = '{1'b0, 4'd0,  1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[15] = '{1'b1, 4'd2,  1'b0, 3'd3, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[16] = '{1'b0, 4'd0,  1'b0, 3'd3, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset, then unlock, re-program to 1234, and show the old code now fails.
      do_reset();
      expect_outs("reset", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) begin
         step(vt[i].dv, vt[i].d, vt[i].pr);
         expect_outs($sformatf("vec%0d", i), vt[i].st, vt[i].dc, vt[i].fc,
                     vt[i].un, vt[i].lk, vt[i].ep, vt[i].cu);
      end
      wait_ticks(ERR_CYCLES - 2);
      expect_outs("err_last_cycle", 3'd3, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      expect_outs("err_to_idle", 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      enter4(4'd1, 4'd2, 4'd3, 4'd4);
      expect_outs("new_code_unlock", 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Three wrong attempts at positions 1, 2 and 4 lead to lockout.
      do_reset();
      step(1'b1, 4'd1, 1'b0);
      expect_outs("wrong1st", 3'd3, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_ticks(ERR_CYCLES - 1);
      expect_outs("wrong1st_hold", 3'd3, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      expect_outs("wrong1st_idle", 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd2, 1'b0);
      step(1'b1, 4'd1, 1'b0);
      expect_outs("wrong2nd", 3'd3, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_ticks(ERR_CYCLES);
      expect_outs("wrong2nd_idle", 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      enter4(4'd2, 4'd0, 4'd1, 4'd2);
      expect_outs("wrong4th", 3'd3, 3'd0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_ticks(ERR_CYCLES - 1);
      expect_outs("wrong4th_hold", 3'd3, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      expect_outs("lockout_entry", 3'd4, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      enter4(4'd2, 4'd0, 4'd1, 4'd6);
      expect_outs("lockout_ignores", 3'd4, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_ticks(LOCK_CYCLES - 5);
      expect_outs("lockout_last", 3'd4, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      expect_outs("lockout_end", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      enter4(4'd2, 4'd0, 4'd1, 4'd6);
      expect_outs("post_lock_unlock", 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Unlock duration with no input.
      wait_ticks(UNLOCK_CYCLES - 1);
      expect_outs("unlock_last", 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      expect_outs("unlock_relock", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset during PROG discards the partial code.
      enter4(4'd2, 4'd0, 4'd1, 4'd6);
      step(1'b0, 4'd0, 1'b1);
      step(1'b1, 4'd5, 1'b0);
      step(1'b1, 4'd5, 1'b0);
      expect_outs("prog_partial", 3'd5, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_reset();
      expect_outs("prog_reset", 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd5, 1'b0);
      expect_outs("old_code_kept", 3'd3, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      do_reset();
      step(1'b1, 4'd12, 1'b0);
      expect_outs("digit_gt9", 3'd3, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      do_reset();
      enter4(4'd2, 4'd0, 4'd1, 4'd6);
      expect_outs("2016_after_reset", 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // prog_req + digit_valid in the cycle the unlock timer expires.
      wait_ticks(UNLOCK_CYCLES - 1);
      step(1'b1, 4'd7, 1'b1);
      expect_outs("prog_at_expiry", 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd7, 1'b0);
      expect_outs("prog_first_digit", 3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_password_seq_ctrl
